relay_encode_multi: RTL and testbench

- Parametrised successor of the relay encoder for the relay path.
- Oversamples the incoming demodulated relay bitstream and encodes ISO14443A reader symbols (Miller) or tag load-modulation bursts into timed output pulses for the downstream modulator.
- Adds over the previous generation: configurable sample rate and pulse length, passthrough and disabled modes, symbol error detection, frame status and a symbol counter.

---
 rtl/relay_encode_multi.sv | 237 +++++++++++++++++++++++
 tb/tb_relay_encode_multi.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relay_encode_multi.sv
// relay_encode_multi
//   Oversamples the demodulated relay bitstream and re-encodes it as timed
//   pulses for the downstream modulator. Reader mode decodes ISO14443A
//   Miller symbols into half-bit pulses. Tag mode turns load-modulation
//   bursts into single pulses. Passthrough and disabled modes are also
//   provided.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   mode[1:0]     00 reader encode, 01 tag encode, 10 passthrough, 11 disabled
//   data_in       demodulated relay bitstream
//   data_out      encoded modulation output (registered)
//   frame_active  high while a reader frame is being decoded
//   symbol_err    one-cycle pulse on an invalid reader symbol
//   bit_count     valid symbols (reader) or pulses (tag) since frame start
//                 or mode change; saturates at all-ones
module relay_encode_multi #(
  parameter int SAMPLE_DIV = 16,
  parameter int HALF_LEN   = 64,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             data_in,
  output logic             data_out,
  output logic             frame_active,
  output logic             symbol_err,
  output logic [CNT_W-1:0] bit_count
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int LEN_W = $clog2(HALF_LEN + 1);
  localparam logic [LEN_W-1:0] HALF = LEN_W'(HALF_LEN);

  typedef enum logic [1:0] {
    M_READER = 2'b00,
    M_TAG    = 2'b01,
    M_PASS   = 2'b10,
    M_OFF    = 2'b11
  } mode_t;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  state_t           state;
  mode_t            mode_q;
  logic [DIV_W-1:0] div;
  logic [7:0]       sample_buf;
  logic [2:0]       slot;
  logic             zero_seen;
  logic [LEN_W-1:0] low_cnt;
  logic [LEN_W-1:0] high_cnt;

  logic             tick;
  logic             mode_chg;
  logic [7:0]       shifted;
  logic             is_ff;
  logic             lo_f;
  logic             hi_f;
  logic             start_ok;
  logic [CNT_W-1:0] bc_inc;

  logic             req_x;
  logic             req_y;
  logic             frame_start;
  logic             frame_stop;
  logic             sym_ok;
  logic             sym_bad;
  logic             tag_hit;

  // Divider is a power of two, so it wraps naturally; the tick is the
  // clock on which it wraps back to zero.
  assign tick     = &div;
  assign mode_chg = (mode_t'(mode) != mode_q);
  assign shifted  = {sample_buf[6:0], data_in};
  assign is_ff    = (shifted == 8'hFF);
  assign lo_f     = (shifted[3:0] == 4'hF);
  assign hi_f     = (shifted[7:4] == 4'hF);
  assign start_ok = (shifted[7:6] == 2'b00) && lo_f;
  assign bc_inc   = (bit_count == '1) ? bit_count : bit_count + 1'b1;

  // Symbol decisions are made on the freshly shifted window, so a tick
  // both captures its sample and classifies the byte it completes.
  always_comb begin
    req_x       = 1'b0;
    req_y       = 1'b0;
    frame_start = 1'b0;
    frame_stop  = 1'b0;
    sym_ok      = 1'b0;
    sym_bad     = 1'b0;
    tag_hit     = 1'b0;
    if (!mode_chg && tick) begin
      unique case (mode_q)
        M_READER: begin
          if (state == ST_IDLE) begin
            if (start_ok) begin
              frame_start = 1'b1;
              req_x       = 1'b1;
            end
          end else if (slot == 3'd7) begin
            if (is_ff && zero_seen) begin
              frame_stop = 1'b1;
            end else if (is_ff) begin
              sym_ok = 1'b1;
            end else if (lo_f) begin
              req_x  = 1'b1;
              sym_ok = 1'b1;
            end else if (hi_f) begin
              req_y  = 1'b1;
              sym_ok = 1'b1;
            end else begin
              sym_bad = 1'b1;
            end
          end
        end
        M_TAG: begin
          if (shifted == 8'h0E || shifted == 8'h0F) begin
            tag_hit = 1'b1;
            req_x   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      mode_q       <= M_READER;
      div          <= '0;
      sample_buf   <= '0;
      slot         <= '0;
      zero_seen    <= 1'b0;
      frame_active <= 1'b0;
      symbol_err   <= 1'b0;
      bit_count    <= '0;
    end else begin
      div        <= div + 1'b1;
      mode_q     <= mode_t'(mode);
      symbol_err <= 1'b0;
      if (mode_chg) begin
        state        <= ST_IDLE;
        frame_active <= 1'b0;
        sample_buf   <= '0;
        slot         <= '0;
        zero_seen    <= 1'b0;
        bit_count    <= '0;
      end else begin
        case (mode_q)
          M_READER: begin
            if (tick) begin
              sample_buf <= shifted;
              slot       <= slot + 1'b1;
              if (frame_start) begin
                state        <= ST_ACTIVE;
                frame_active <= 1'b1;
                slot         <= '0;
                zero_seen    <= 1'b1;
                bit_count    <= CNT_W'(1);
              end
              if (sym_ok) begin
                zero_seen <= !req_y;
                bit_count <= bc_inc;
              end
              if (frame_stop || sym_bad) begin
                state        <= ST_IDLE;
                frame_active <= 1'b0;
              end
              if (sym_bad) begin
                symbol_err <= 1'b1;
              end
            end
          end
          M_TAG: begin
            if (tick) begin
              slot <= slot + 1'b1;
              if (tag_hit) begin
                sample_buf <= '0;
                bit_count  <= bc_inc;
              end else begin
                sample_buf <= shifted;
              end
            end
          end
          default: begin
            state        <= ST_IDLE;
            frame_active <= 1'b0;
            sample_buf   <= '0;
            slot         <= '0;
            bit_count    <= '0;
          end
        endcase
      end
    end
  end

  // Pulse generator: low_cnt counts the leading low half of a Y request,
  // high_cnt the high half. A request loads the counters directly, which
  // also makes the newest request win over one still in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= 1'b0;
      low_cnt  <= '0;
      high_cnt <= '0;
    end else if (mode_chg || sym_bad) begin
      data_out <= 1'b0;
      low_cnt  <= '0;
      high_cnt <= '0;
    end else if (mode_q == M_PASS) begin
      data_out <= data_in;
      low_cnt  <= '0;
      high_cnt <= '0;
    end else if (req_x) begin
      data_out <= 1'b1;
      low_cnt  <= '0;
      high_cnt <= HALF - 1'b1;
    end else if (req_y) begin
      data_out <= 1'b0;
      low_cnt  <= HALF - 1'b1;
      high_cnt <= HALF;
    end else if (low_cnt != '0) begin
      data_out <= 1'b0;
      low_cnt  <= low_cnt - 1'b1;
    end else if (high_cnt != '0) begin
      data_out <= 1'b1;
      high_cnt <= high_cnt - 1'b1;
    end else begin
      data_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_relay_encode_multi.sv
module tb_relay_encode_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode_d [2];
  logic       data_d [2];

  logic       dout0, fa0, se0;
  logic [7:0] bc0;
  logic       dout1, fa1, se1;
  logic [1:0] bc1;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state, one slot per DUT instance.
  int         n_edge = 0;
  logic [1:0] mq [2];
  int         win [2];
  bit         act [2];
  bit         zs [2];
  int         cnt [2];
  int         tks [2];
  int         rk [2];
  int         rt [2];
  bit         er [2];
  bit         pt [2];
  bit         tick_hit [2];
  bit         chg [2];
  int         hc [2];

  always #5 clk = ~clk;

  relay_encode_multi #(.SAMPLE_DIV(16), .HALF_LEN(64), .CNT_W(8)) u0 (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode_d[0]),
    .data_in      (data_d[0]),
    .data_out     (dout0),
    .frame_active (fa0),
    .symbol_err   (se0),
    .bit_count    (bc0)
  );

  relay_encode_multi #(.SAMPLE_DIV(4), .HALF_LEN(8), .CNT_W(2)) u1 (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode_d[1]),
    .data_in      (data_d[1]),
    .data_out     (dout1),
    .frame_active (fa1),
    .symbol_err   (se1),
    .bit_count    (bc1)
  );

  function automatic int div_of(int k);
    return (k == 0) ? 16 : 4;
  endfunction

  function automatic int half_of(int k);
    return (k == 0) ? 64 : 8;
  endfunction

  function automatic int maxc_of(int k);
    return (k == 0) ? 255 : 3;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic bump(int k);
    if (cnt[k] < maxc_of(k)) cnt[k]++;
  endtask

  task automatic classify(int k, int b);
    if (b == 255 && zs[k]) begin
      act[k] = 1'b0;
    end else if (b == 255) begin
      zs[k] = 1'b1;
      bump(k);
    end else if (b % 16 == 15) begin
      rk[k] = 1; rt[k] = n_edge; zs[k] = 1'b1;
      bump(k);
    end else if (b / 16 == 15) begin
      rk[k] = 2; rt[k] = n_edge; zs[k] = 1'b0;
      bump(k);
    end else begin
      er[k] = 1'b1; rk[k] = 0; act[k] = 1'b0;
    end
  endtask

  task automatic model_edge(int k, bit r);
    bit tk;
    tick_hit[k] = 1'b0;
    er[k]       = 1'b0;
    if (r) begin
      mq[k] = 2'd0; win[k] = 0; act[k] = 1'b0; zs[k] = 1'b0; cnt[k] = 0;
      rk[k] = 0; pt[k] = 1'b0; chg[k] = 1'b0; tks[k] = 0;
      return;
    end
    tk          = (n_edge % div_of(k)) == 0;
    tick_hit[k] = tk;
    chg[k]      = (mode_d[k] != mq[k]);
    if (chg[k]) begin
      mq[k] = mode_d[k]; win[k] = 0; act[k] = 1'b0; cnt[k] = 0;
      rk[k] = 0; pt[k] = 1'b0;
      return;
    end
    case (mq[k])
      2'd0: if (tk) begin
        win[k] = (win[k] * 2 + int'(data_d[k])) % 256;
        if (!act[k]) begin
          if (win[k] / 64 == 0 && win[k] % 16 == 15) begin
            act[k] = 1'b1; tks[k] = 0; zs[k] = 1'b0; cnt[k] = 0;
            classify(k, win[k]);
          end
        end else begin
          tks[k]++;
          if (tks[k] % 8 == 0) classify(k, win[k]);
        end
      end
      2'd1: if (tk) begin
        win[k] = (win[k] * 2 + int'(data_d[k])) % 256;
        if (win[k] == 14 || win[k] == 15) begin
          rk[k] = 1; rt[k] = n_edge; win[k] = 0;
          bump(k);
        end
      end
      2'd2: pt[k] = data_d[k];
      default: ;
    endcase
  endtask

  function automatic bit exp_dout(int k);
    int dt;
    if (mq[k] == 2'd2 && !chg[k]) return pt[k];
    dt = n_edge - rt[k];
    if (rk[k] == 1) return dt < half_of(k);
    if (rk[k] == 2) return (dt >= half_of(k)) && (dt < 2 * half_of(k));
    return 1'b0;
  endfunction

  task automatic check_all();
    chk("dout0", 32'(dout0), 32'(exp_dout(0)));
    chk("frame_active0", 32'(fa0), 32'(act[0]));
    chk("symbol_err0", 32'(se0), 32'(er[0]));
    chk("bit_count0", 32'(bc0), 32'(cnt[0]));
    chk("dout1", 32'(dout1), 32'(exp_dout(1)));
    chk("frame_active1", 32'(fa1), 32'(act[1]));
    chk("symbol_err1", 32'(se1), 32'(er[1]));
    chk("bit_count1", 32'(bc1), 32'(cnt[1]));
    if (dout0 === 1'b1) hc[0]++;
    if (dout1 === 1'b1) hc[1]++;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset) n_edge = 0;
    else n_edge++;
    model_edge(0, reset);
    model_edge(1, reset);
    #1;
    check_all();
  endtask

  task automatic send_sample(int k, logic b);
    int guard;
    guard     = 0;
    data_d[k] = b;
    do begin
      cyc();
      guard++;
    end while (!tick_hit[k] && guard < 64);
    if (!tick_hit[k]) begin
      vectors++;
      miscompares++;
      $error("FAIL tick_timeout: inst %0d saw no tick in %0d cycles", k, guard);
    end
  endtask

  task automatic send_byte(int k, logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_sample(k, v[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int         k;
    int         r;
    logic       prev;

    reset = 1'b1;
    mode_d[0] = 2'd0; data_d[0] = 1'b1;
    mode_d[1] = 2'd3; data_d[1] = 1'b0;
    hc[0] = 0; hc[1] = 0;
    repeat (3) cyc();
    chk("rst_dout", 32'(dout0), 32'd0);
    chk("rst_fa", 32'(fa0), 32'd0);
    chk("rst_bc", 32'(bc0), 32'd0);
    reset = 1'b0;
    data_d[0] = 1'b0;

    // Reader frame: X, Y, FF (counted), FF (end of frame).
    hc[0] = 0;
    send_byte(0, 8'h0F);
    chk("x_start_dout", 32'(dout0), 32'd1);
    chk("x_start_fa", 32'(fa0), 32'd1);
    chk("x_start_bc", 32'(bc0), 32'd1);
    send_byte(0, 8'hF0);
    chk("x_len", 32'(hc[0]), 32'd64);
    chk("y_start_low", 32'(dout0), 32'd0);
    chk("y_bc", 32'(bc0), 32'd2);
    hc[0] = 0;
    send_byte(0, 8'hFF);
    chk("y_high_len", 32'(hc[0]), 32'd64);
    chk("ff1_fa", 32'(fa0), 32'd1);
    hc[0] = 0;
    send_byte(0, 8'hFF);
    chk("ff_nopulse", 32'(hc[0]), 32'd0);
    chk("eof_fa", 32'(fa0), 32'd0);
    chk("eof_bc", 32'(bc0), 32'd3);

    // Invalid symbol inside an active frame.
    send_byte(0, 8'h0F);
    send_byte(0, 8'h55);
    chk("err_pulse", 32'(se0), 32'd1);
    chk("err_fa", 32'(fa0), 32'd0);
    chk("err_dout", 32'(dout0), 32'd0);
    cyc();
    chk("err_one_cycle", 32'(se0), 32'd0);

    // Mode change to passthrough in the middle of an X pulse.
    send_byte(0, 8'h0F);
    repeat (19) cyc();
    chk("mid_pulse", 32'(dout0), 32'd1);
    mode_d[0] = 2'd2;
    data_d[0] = 1'b1;
    cyc();
    chk("chg_dout", 32'(dout0), 32'd0);
    for (int unsigned i = 0; i < 12; i++) begin
      data_d[0] = 1'($urandom_range(0, 1));
      prev      = data_d[0];
      cyc();
      chk("pass_track", 32'(dout0), 32'(prev));
      chk("pass_bc", 32'(bc0), 32'd0);
    end

    // Tag mode: 0x0E fires, then ones re-form 0x0F after four samples.
    mode_d[0] = 2'd1;
    data_d[0] = 1'b0;
    cyc();
    send_byte(0, 8'h0E);
    chk("tag_bc1", 32'(bc0), 32'd1);
    chk("tag_dout", 32'(dout0), 32'd1);
    chk("tag_fa", 32'(fa0), 32'd0);
    repeat (3) send_sample(0, 1'b1);
    chk("tag_no_retrig", 32'(bc0), 32'd1);
    send_sample(0, 1'b1);
    chk("tag_retrig", 32'(bc0), 32'd2);

    // Small instance: Y timing and bit_count saturation.
    mode_d[0] = 2'd3;
    mode_d[1] = 2'd0;
    data_d[1] = 1'b0;
    cyc();
    send_byte(1, 8'h0F);
    send_byte(1, 8'hF0);
    chk("y8_start_low", 32'(dout1), 32'd0);
    hc[1]     = 0;
    data_d[1] = 1'b0;
    repeat (7) cyc();
    chk("y8_low", 32'(hc[1]), 32'd0);
    repeat (8) cyc();
    chk("y8_high", 32'(hc[1]), 32'd8);
    cyc();
    chk("y8_end", 32'(dout1), 32'd0);
    repeat (4) send_sample(1, 1'b1);
    chk("sat_bc3", 32'(bc1), 32'd3);
    send_byte(1, 8'hF0);
    send_byte(1, 8'hFF);
    chk("sat_hold", 32'(bc1), 32'd3);
    send_byte(1, 8'hFF);
    chk("sat_eof_fa", 32'(fa1), 32'd0);
    chk("sat_eof_bc", 32'(bc1), 32'd3);

    // Randomized traffic on both instances, occasional mode changes.
    for (int unsigned it = 0; it < 48; it++) begin
      k = int'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        mode_d[k] = 2'($urandom_range(0, 3));
        cyc();
      end
      r = int'($urandom_range(0, 4));
      case (r)
        0: v = 8'h0F;
        1: v = 8'hF0;
        2: v = 8'hFF;
        3: v = 8'h0E;
        default: v = 8'($urandom_range(0, 255));
      endcase
      send_byte(k, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
